// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit ripple slice per clock, LSB slice first.
// Define SEQ_CHUNK_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_c, last;
    int unsigned      base;

    // Current slice; b_q already holds ~b for subtract, carry_q starts at 1.
    always_comb begin
        base         = int'(cnt_q) * CHUNK;
        sl_a         = a_q[base +: CHUNK];
        sl_b         = b_q[base +: CHUNK];
        {sl_c, sl_s} = {1'b0, sl_a} + {1'b0, sl_b} + {{CHUNK{1'b0}}, carry_q};
        last         = (cnt_q == CW'(NCHUNK - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        if (state_q == IDLE) begin
            if (start) begin
                a_d     = a;
                b_d     = sub ? ~b : b;
                carry_d = sub;
                cnt_d   = '0;
                sum_d   = '0;
                cout_d  = 1'b0;
                ovf_d   = 1'b0;
                busy_d  = 1'b1;
            end
        end else begin
            sum_d[base +: CHUNK] = sl_s;
            carry_d              = sl_c;
            cnt_d                = cnt_q + 1'b1;
            if (last) begin
                cnt_d  = '0;
                cout_d = sl_c;
                // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
                ovf_d  = sl_a[CHUNK-1] ^ sl_b[CHUNK-1] ^ sl_s[CHUNK-1] ^ sl_c;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: vector table, handshake/reset sequences and a random
// sweep over several WIDTH/CHUNK builds checked against an arithmetic model.
module tb_seq_chunk_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [4:0] start_v = '0;

    logic       busy_w [5];
    logic       done_w [5];
    logic       cout_w [5];
    logic       ovf_w  [5];
    logic [7:0] s8     [4];
    logic [15:0] s16;

    // idx: 0 = (8,2)  1 = (8,1)  2 = (8,4)  3 = (8,8)  4 = (16,4)
    int wid [5] = '{8, 8, 8, 8, 16};
    int nch [5] = '{4, 8, 2, 1, 4};

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(2)) u0 (.clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .busy(busy_w[0]), .done(done_w[0]), .sum(s8[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(1)) u1 (.clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .busy(busy_w[1]), .done(done_w[1]), .sum(s8[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(4)) u2 (.clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .busy(busy_w[2]), .done(done_w[2]), .sum(s8[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(8)) u3 (.clk(clk), .rst(rst), .start(start_v[3]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .busy(busy_w[3]), .done(done_w[3]), .sum(s8[3]), .cout(cout_w[3]), .ovf(ovf_w[3]));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u4 (.clk(clk), .rst(rst), .start(start_v[4]), .sub(sub), .a(a), .b(b), .busy(busy_w[4]), .done(done_w[4]), .sum(s16), .cout(cout_w[4]), .ovf(ovf_w[4]));
`else
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(2)) u0 (.clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .busy(busy_w[0]), .done(done_w[0]), .sum(s8[0]), .cout(cout_w[0]));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(1)) u1 (.clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .busy(busy_w[1]), .done(done_w[1]), .sum(s8[1]), .cout(cout_w[1]));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(4)) u2 (.clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .busy(busy_w[2]), .done(done_w[2]), .sum(s8[2]), .cout(cout_w[2]));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(8)) u3 (.clk(clk), .rst(rst), .start(start_v[3]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .busy(busy_w[3]), .done(done_w[3]), .sum(s8[3]), .cout(cout_w[3]));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u4 (.clk(clk), .rst(rst), .start(start_v[4]), .sub(sub), .a(a), .b(b), .busy(busy_w[4]), .done(done_w[4]), .sum(s16), .cout(cout_w[4]));
    initial for (int i = 0; i < 5; i++) ovf_w[i] = 1'b0;
`endif

    function automatic logic [15:0] pick_sum(int idx);
        return (idx == 4) ? s16 : {8'h00, s8[idx]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(int w, logic [15:0] av, logic [15:0] bv, logic sv,
                         output logic [15:0] s, output logic c, output logic o);
        longint m, ua, ub, r, sa, sb, sr, half;
        m    = (64'sd1 << w) - 1;
        half = 64'sd1 << (w - 1);
        ua   = longint'(av) & m;
        ub   = longint'(bv) & m;
        r    = sv ? (ua - ub) : (ua + ub);
        s    = 16'(r & m);
        c    = sv ? (ua >= ub) : (r > m);
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        sr   = sv ? (sa - sb) : (sa + sb);
        o    = (sr >= half) || (sr < -half);
    endtask

    // Issue one op on instance idx and wait for done; lat = -1 on timeout.
    task automatic do_op(int idx, logic [15:0] av, logic [15:0] bv, logic sv,
                         output logic [15:0] gs, output logic gc, output logic go, output int lat);
        a = av; b = bv; sub = sv;
        start_v[idx] = 1'b1;
        tick();
        start_v[idx] = 1'b0;
        chk("busy_after_start", busy_w[idx], 1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_w[idx]) begin
                lat = k;
                break;
            end
        end
        gs = pick_sum(idx); gc = cout_w[idx]; go = ovf_w[idx];
        chk("busy_at_done", busy_w[idx], 0);
        tick();
        chk("done_single_pulse", done_w[idx], 0);
        chk("sum_hold_after_done", pick_sum(idx), gs);
    endtask

    typedef struct {
        int          idx;
        logic [15:0] a, b;
        logic        sub;
        logic [15:0] s;
        logic        c, o;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [15:0] gs, es;
        logic        gc, go, ec, eo;
        int          lat;

        tbl[0]  = '{0, 16'h005A, 16'h003C, 1'b0, 16'h0096, 1'b0, 1'b1};
        tbl[1]  = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1};
        tbl[3]  = '{0, 16'h0010, 16'h0020, 1'b1, 16'h00F0, 1'b0, 1'b0};
        tbl[4]  = '{0, 16'h0020, 16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0};
        tbl[5]  = '{0, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1};
        tbl[6]  = '{0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7]  = '{1, 16'h005A, 16'h003C, 1'b0, 16'h0096, 1'b0, 1'b1};
        tbl[8]  = '{2, 16'h00A5, 16'h005A, 1'b1, 16'h004B, 1'b1, 1'b1};
        tbl[9]  = '{3, 16'h00C8, 16'h0064, 1'b0, 16'h002C, 1'b1, 1'b0};
        tbl[10] = '{4, 16'h1234, 16'hEDCC, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[11] = '{4, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[12] = '{3, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset state
        rst = 1'b1;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("rst_busy", busy_w[i], 0);
            chk("rst_done", done_w[i], 0);
            chk("rst_sum",  pick_sum(i), 0);
            chk("rst_cout", cout_w[i], 0);
        end
        rst = 1'b0;
        tick();

        // Directed vectors
        foreach (tbl[t]) begin
            do_op(tbl[t].idx, tbl[t].a, tbl[t].b, tbl[t].sub, gs, gc, go, lat);
            chk("vec_sum",  gs, tbl[t].s);
            chk("vec_cout", gc, tbl[t].c);
            chk("vec_lat",  lat, nch[tbl[t].idx]);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            chk("vec_ovf",  go, tbl[t].o);
`endif
        end

        // Handshake: start held, operands change mid-run, restart in done cycle
        a = 16'h005A; b = 16'h003C; sub = 1'b0; start_v[0] = 1'b1;
        tick();
        a = 16'h0000; b = 16'h0000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                chk("hs_busy_run", busy_w[0], 1);
                chk("hs_no_done",  done_w[0], 0);
            end
        end
        chk("hs_done",  done_w[0], 1);
        chk("hs_sum",   s8[0], 8'h96);
        a = 16'h0011; b = 16'h0022;
        tick();
        start_v[0] = 1'b0;
        chk("hs_restart_busy", busy_w[0], 1);
        chk("hs_restart_done", done_w[0], 0);
        chk("hs_restart_sum",  s8[0], 0);
        for (int k = 1; k <= 4; k++) tick();
        chk("hs2_done", done_w[0], 1);
        chk("hs2_sum",  s8[0], 8'h33);
        chk("hs2_cout", cout_w[0], 0);
        a = 16'h00FF; b = 16'h00FF; sub = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_sum_stable",  s8[0], 8'h33);
            chk("idle_cout_stable", cout_w[0], 0);
            chk("idle_busy",        busy_w[0], 0);
        end

        // Reset in the second RUN cycle
        a = 16'h00FF; b = 16'h00FF; sub = 1'b0; start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy_w[0], 0);
        chk("midrst_done", done_w[0], 0);
        chk("midrst_sum",  s8[0], 0);
        chk("midrst_cout", cout_w[0], 0);
        begin
            logic saw_done = 1'b0;
            for (int k = 0; k < 6; k++) begin
                tick();
                saw_done |= done_w[0];
            end
            chk("midrst_no_done", saw_done, 0);
        end
        do_op(0, 16'h0044, 16'h0033, 1'b0, gs, gc, go, lat);
        chk("postrst_sum", gs, 16'h0077);
        chk("postrst_lat", lat, 4);

        // Random sweep against the model
        for (int i = 0; i < 200 + 4 * 25; i++) begin
            int idx;
            logic [15:0] ra, rb;
            logic rs;
            idx = (i < 200) ? 4 : (i - 200) / 25;
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rs  = 1'($urandom);
            if (wid[idx] == 8) begin
                ra[15:8] = '0;
                rb[15:8] = '0;
            end
            model(wid[idx], ra, rb, rs, es, ec, eo);
            do_op(idx, ra, rb, rs, gs, gc, go, lat);
            chk("rnd_sum",  gs, es);
            chk("rnd_cout", gc, ec);
            chk("rnd_lat",  lat, nch[idx]);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            chk("rnd_ovf",  go, eo);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle add/subtract unit. Processes two WIDTH-bit operands one CHUNK-bit ripple slice per clock, LSB slice first, with a start/busy/done handshake. Carry is held in a register between slices. Sits between switch/register-file operand sources and result displays or accumulators.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
CHUNK, 2, bits added per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0 (elaboration error otherwise).
NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only while IDLE
sub  in  1  0 = a+b, 1 = a-b; latched with operands
a  in  WIDTH  operand A; latched on accepted start
b  in  WIDTH  operand B; latched on accepted start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse; result valid from this cycle
sum  out  WIDTH  result, modulo 2^WIDTH
cout  out  1  final carry; for sub, 1 = no borrow (a >= b unsigned)

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, slice counter=0, carry register=0, operand registers=0. rst overrides start.
- States: IDLE, RUN.
- IDLE:
  - done is cleared at every edge unless set by the RUN->IDLE transition.
  - start=1 at edge E0: latch A=a, B = sub ? ~b : b, carry register = sub, counter=0, sum=0, cout=0, busy=1, state -> RUN.
  - start=0: sum and cout hold their values.
- RUN, edge Ek (k = 1..NCHUNK), slice i = k-1:
  - {c, s} = A[i*CHUNK +: CHUNK] + B[i*CHUNK +: CHUNK] + carry register.
  - Write s into sum[i*CHUNK +: CHUNK]; carry register <= c; counter <= counter + 1.
- Last slice (counter == NCHUNK-1):
  - cout <= c, busy <= 0, done <= 1, state -> IDLE.
- Latency: start sampled at E0; done and the final sum/cout are visible after E_NCHUNK.
- Throughput: start may be asserted in the done cycle and is accepted at the next edge, so the period is NCHUNK+1 edges per operation.
- start, a, b, sub are ignored while busy=1. Operand changes during RUN do not affect the result.
- sum holds partial slices during RUN. Consumers use it only at or after done.
- Result and cout hold after done until the next accepted start or reset.
- CHUNK == WIDTH: single RUN cycle; done after E1.
- Subtract: two's-complement A + ~B + 1. Example: a=0, b=0, sub=1 gives sum=0, cout=1.
- Reset during RUN: abandon the operation immediately; no done pulse.

Optional Feature:
Macro SEQ_CHUNK_ADDER_OVF_EN.
- Defined: extra output port ovf (out, 1), signed two's-complement overflow. ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. The carry into the MSB is taken inside the last slice. ovf is written at the same edge as cout, held until the next accepted start, and reset to 0. For sub, it uses the inverted B and carry-in 1.
- Not defined: no ovf port and no related logic; all other behaviour is identical.

Test Plan:
1. WIDTH=8, CHUNK=2: rst 2 cycles, then a=0x5A, b=0x3C, sub=0, start 1 cycle -> busy high 4 cycles; done pulse after 4th RUN edge; sum=0x96, cout=0 (ovf=1 with macro).
2. a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
3. Subtract: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0. Then a=0x20, b=0x10 -> sum=0x10, cout=1. Then a=0x80, b=0x01 -> sum=0x7F, ovf=1.
4. Handshake: start held high and a changed to 0x00 during RUN -> no restart, result from latched operands. start asserted in the done cycle -> next op accepted with busy=1 next cycle. sum/cout are stable while idle.
5. rst asserted at 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse. A following start completes normally.
6. Parameter sweep: CHUNK=1, CHUNK=4 and CHUNK=WIDTH=8 (done after 1 RUN edge); WIDTH=16, CHUNK=4 with 200 random add/sub ops checked against a reference model and latency NCHUNK.
